ca_row_writer: RTL and testbench



---
 rtl/ca_row_writer.sv | 128 ++++++++++++
 tb/tb_ca_row_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_row_writer.sv
// ca_row_writer: elementary cellular-automaton generator that fills a 64x128-cell
// debug RAM one generation per row through a byte-wide write port.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; outputs quiet
// S_WRITE | writing byte 'byte_q' of row 'row_q' from cur_q
// S_STEP  | one cycle: cur_q advances to the next generation
// S_DONE  | one-cycle done pulse after the final write of row 63
module ca_row_writer #(
    parameter int SEED_CELL = 64,
    parameter bit WRAP      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] rule,
    output logic       ram_en,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_STEP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [127:0] SEED_ROW = 128'd1 << SEED_CELL;

    state_t         state_q, state_d;
    logic [127:0]   cur_q, cur_d;
    logic [5:0]     row_q, row_d;
    logic [3:0]     byte_q, byte_d;
    logic [7:0]     rule_q, rule_d;

    logic [129:0]   ext_row;
    logic [127:0]   next_gen;
    logic [7:0]     raw_byte;
    logic [7:0]     out_byte;

    // Neighbourhood evaluation; ext_row pads the row with the edge neighbours so
    // cell i sees {ext_row[i], ext_row[i+1], ext_row[i+2]} as {left, centre, right}.
    always_comb begin
        ext_row  = {(WRAP ? cur_q[0] : 1'b0), cur_q, (WRAP ? cur_q[127] : 1'b0)};
        next_gen = '0;
        for (int i = 0; i < 128; i++) begin
            next_gen[i] = rule_q[{ext_row[i], ext_row[i + 1], ext_row[i + 2]}];
        end
    end

    // Byte extraction: the lowest-numbered cell of a byte lands on bit 7.
    always_comb begin
        raw_byte = cur_q[{byte_q, 3'b000} +: 8];
        out_byte = '0;
        for (int j = 0; j < 8; j++) begin
            out_byte[j] = raw_byte[7 - j];
        end
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        row_d   = row_q;
        byte_d  = byte_q;
        rule_d  = rule_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d   = SEED_ROW;
                    row_d   = 6'd0;
                    byte_d  = 4'd0;
                    rule_d  = rule;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                byte_d = byte_q + 4'd1;
                if (byte_q == 4'hF) begin
                    state_d = (row_q == 6'h3F) ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                cur_d   = next_gen;
                row_d   = row_q + 6'd1;
                byte_d  = 4'd0;
                state_d = S_WRITE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            row_q   <= '0;
            byte_q  <= '0;
            rule_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            row_q   <= row_d;
            byte_q  <= byte_d;
            rule_q  <= rule_d;
        end
    end

    // Outputs depend only on registered state; address and data are zero when not writing.
    always_comb begin
        ram_en   = (state_q == S_WRITE);
        ram_addr = ram_en ? {row_q, byte_q} : 10'd0;
        ram_data = ram_en ? out_byte : 8'd0;
        busy     = (state_q == S_WRITE) || (state_q == S_STEP);
        done     = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_ca_row_writer.sv
// Directed testbench for ca_row_writer: captures every RAM write into shadow
// memories and compares against hand-computed generation contents and timing.
module tb_ca_row_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rule;

    logic       ram_en, busy, done;
    logic [9:0] ram_addr;
    logic [7:0] ram_data;
    logic       w1_en, w1_busy, w1_done;
    logic [9:0] w1_addr;
    logic [7:0] w1_data;
    logic       w0_en, w0_busy, w0_done;
    logic [9:0] w0_addr;
    logic [7:0] w0_data;

    ca_row_writer #(.SEED_CELL(64), .WRAP(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .rule(rule),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_data(ram_data),
        .busy(busy), .done(done)
    );

    ca_row_writer #(.SEED_CELL(127), .WRAP(1'b1)) dut_wrap1 (
        .clk(clk), .rst(rst), .start(start), .rule(rule),
        .ram_en(w1_en), .ram_addr(w1_addr), .ram_data(w1_data),
        .busy(w1_busy), .done(w1_done)
    );

    ca_row_writer #(.SEED_CELL(127), .WRAP(1'b0)) dut_wrap0 (
        .clk(clk), .rst(rst), .start(start), .rule(rule),
        .ram_en(w0_en), .ram_addr(w0_addr), .ram_data(w0_data),
        .busy(w0_busy), .done(w0_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem  [1024];
    logic [7:0] mem1 [1024];
    logic [7:0] mem0 [1024];
    int wcount, order_err, done_cnt, done_cyc, w1_done_cnt, w0_done_cnt;
    int last_rel, extra_done, extra_en;
    logic busy_first, busy_last, busy_at_done, finished;
    logic [9:0] last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: single start pulse; 1: start pulses and rule changes while busy;
    // 2: start held high, checks the back-to-back restart after done.
    task automatic run_capture(input logic [7:0] r, input int mode);
        int base, rel, n, k;
        for (int a = 0; a < 1024; a++) begin
            mem[a] = 8'hEE; mem1[a] = 8'hEE; mem0[a] = 8'hEE;
        end
        wcount = 0; order_err = 0; done_cnt = 0; done_cyc = -1;
        w1_done_cnt = 0; w0_done_cnt = 0; last_rel = -1; last_addr = '0;
        busy_first = 1'b0; busy_last = 1'b0; busy_at_done = 1'b1; finished = 1'b0;
        extra_done = 0; extra_en = 0;
        @(negedge clk);
        start = 1'b1;
        rule  = r;
        base  = cyc;
        n = 0;
        while (!finished && n < 1500) begin
            @(negedge clk);
            n++;
            rel = cyc - base;
            if (ram_en) begin
                k = wcount;
                if (ram_addr !== k[9:0] || rel != 1 + 17 * (k / 16) + (k % 16))
                    order_err++;
                mem[ram_addr] = ram_data;
                last_addr = ram_addr;
                last_rel = rel;
                wcount++;
            end
            if (w1_en) mem1[w1_addr] = w1_data;
            if (w0_en) mem0[w0_addr] = w0_data;
            if (w1_done) w1_done_cnt++;
            if (w0_done) w0_done_cnt++;
            if (rel == 1) busy_first = busy;
            if (rel == 1087) busy_last = busy;
            if (done) begin
                done_cnt++;
                done_cyc = rel;
                busy_at_done = busy;
                finished = 1'b1;
            end
            if (mode == 1) begin
                start = (rel == 100 || rel == 500 || rel == 1000);
                if (rel == 300) rule = 8'h5A;
                if (rel == 700) rule = 8'h00;
            end else if (mode == 0) begin
                start = 1'b0;
            end
        end
        check("run_finished", {31'd0, finished}, 32'd1);
        if (mode == 2) begin
            @(negedge clk);
            check("b2b_idle_en", {31'd0, ram_en}, 32'd0);
            check("b2b_idle_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            check("b2b_restart_en", {31'd0, ram_en}, 32'd1);
            check("b2b_restart_addr", {22'd0, ram_addr}, 32'd0);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (done) extra_done++;
                if (ram_en) extra_en++;
            end
            check("post_done_pulses", extra_done, 0);
            check("post_done_writes", extra_en, 0);
        end
    endtask

    initial begin
        int bad, base, rel;
        rst   = 1'b1;
        start = 1'b1;
        rule  = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_ram_en", {31'd0, ram_en}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_en || busy || done || ram_addr != 10'd0 || ram_data != 8'd0 ||
                w1_en || w1_busy || w1_done || w0_en || w0_busy || w0_done)
                bad++;
        end
        check("reset_quiet_20", bad, 0);

        // Rule 0: only the seed row carries a live cell.
        run_capture(8'd0, 0);
        check("r0_seed_byte", {24'd0, mem[10'h008]}, 32'h80);
        bad = 0;
        for (int a = 0; a < 1024; a++)
            if (a != 8 && mem[a] !== 8'h00) bad++;
        check("r0_other_bytes", bad, 0);
        check("r0_write_count", wcount, 1024);
        check("r0_write_order", order_err, 0);
        check("r0_done_cycle", done_cyc, 1088);
        check("r0_done_count", done_cnt, 1);
        check("r0_last_write_cyc", last_rel, 1087);
        check("r0_last_write_addr", {22'd0, last_addr}, 32'h3FF);
        check("r0_busy_cycle1", {31'd0, busy_first}, 32'd1);
        check("r0_busy_cycle1087", {31'd0, busy_last}, 32'd1);
        check("r0_busy_at_done", {31'd0, busy_at_done}, 32'd0);
        check("r0_wrap_done_counts", w1_done_cnt + w0_done_cnt, 2);

        // Rule 90: Sierpinski spreading from cell 64.
        run_capture(8'd90, 0);
        check("r90_row1_b7", {24'd0, mem[10'h017]}, 32'h01);
        check("r90_row1_b8", {24'd0, mem[10'h018]}, 32'h40);
        bad = 0;
        for (int b = 0; b < 16; b++)
            if (b != 7 && b != 8 && mem[16 + b] !== 8'h00) bad++;
        check("r90_row1_others", bad, 0);
        check("r90_row2_b7", {24'd0, mem[10'h027]}, 32'h02);
        check("r90_row2_b8", {24'd0, mem[10'h028]}, 32'h20);

        // Rule 204: identity, every row equals the seed row.
        run_capture(8'd204, 0);
        bad = 0;
        for (int a = 0; a < 1024; a++)
            if (mem[a] !== ((a % 16 == 8) ? 8'h80 : 8'h00)) bad++;
        check("r204_identity", bad, 0);

        // Rule 240: each cell copies its left neighbour (shift toward higher index).
        run_capture(8'd240, 0);
        check("r240_seed64_row1_b8", {24'd0, mem[10'h018]}, 32'h40);
        check("r240_wrap1_row0_b15", {24'd0, mem1[10'h00F]}, 32'h01);
        check("r240_wrap1_row1_b0", {24'd0, mem1[10'h010]}, 32'h80);
        check("r240_wrap1_row1_b15", {24'd0, mem1[10'h01F]}, 32'h00);
        check("r240_wrap1_row2_b0", {24'd0, mem1[10'h020]}, 32'h40);
        bad = 0;
        for (int b = 0; b < 16; b++)
            if (mem0[16 + b] !== 8'h00) bad++;
        check("r240_wrap0_row1_zero", bad, 0);

        // Start pulses and rule changes during a run must not disturb it.
        run_capture(8'd204, 1);
        bad = 0;
        for (int a = 0; a < 1024; a++)
            if (mem[a] !== ((a % 16 == 8) ? 8'h80 : 8'h00)) bad++;
        check("robust_identity", bad, 0);
        check("robust_done_count", done_cnt, 1);
        check("robust_done_cycle", done_cyc, 1088);
        check("robust_write_count", wcount, 1024);

        // start held high: next run starts after one IDLE cycle.
        run_capture(8'd0, 2);
        check("b2b_done_cycle", done_cyc, 1088);

        // Reset asserted in cycle 500 of a run.
        @(negedge clk);
        start = 1'b1;
        rule  = 8'd204;
        base  = cyc;
        rel   = 0;
        while (rel < 500) begin
            @(negedge clk);
            start = 1'b0;
            rel = cyc - base;
        end
        check("midrst_writing_c500", {31'd0, ram_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_en_c501", {31'd0, ram_en}, 32'd0);
        check("midrst_busy_c501", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_en || busy || done) bad++;
        end
        check("midrst_quiet_after", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
